stack_pop_sequencer: RTL and testbench

Multi-cycle sequencer that pops a block of words off the MIPS stack into the register file. It is the pop counterpart to the datapath's push path. On a start request it reads `count` consecutive words from data memory beginning at the current stack pointer and writes them to consecutive registers. It then writes the advanced stack pointer back to r29. It sits beside the `machine` datapath, sharing the data-memory read port and a register-file write port with it.

---
 rtl/stack_pop_sequencer.sv | 168 ++++++++++++++++
 tb/tb_stack_pop_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_pop_sequencer.sv
// rtl/stack_pop_sequencer.sv - pops a block of stack words into the register file, then updates r29
//
// Ports:
//   clk, reset (async, active-low)
//   start, first_reg[4:0], count[MAX_COUNT_W-1:0], sp_in[31:0] : pop request, sampled in IDLE
//   mem_rd_en, mem_addr[31:0], mem_rdata[31:0]                   : data-memory read port (1-cycle latency)
//   rf_wr_en, rf_wr_addr[4:0], rf_wr_data[31:0]                  : register-file write port
//   busy, done                                                   : status / completion pulse
//   err                                                          : misalignment pulse (STACK_POP_ALIGN_CHECK_EN only)
//
// Optional feature macro: STACK_POP_ALIGN_CHECK_EN
module stack_pop_sequencer #(
    parameter int MAX_COUNT_W = 4,
    parameter int SP_REG      = 29
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4:0]             first_reg,
    input  logic [MAX_COUNT_W-1:0] count,
    input  logic [31:0]            sp_in,
    output logic                   mem_rd_en,
    output logic [31:0]            mem_addr,
    input  logic [31:0]            mem_rdata,
    output logic                   rf_wr_en,
    output logic [4:0]             rf_wr_addr,
    output logic [31:0]            rf_wr_data,
    output logic                   busy,
    output logic                   done
`ifdef STACK_POP_ALIGN_CHECK_EN
    ,
    output logic                   err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    localparam logic [MAX_COUNT_W-1:0] ONE = MAX_COUNT_W'(1);

    state_t                 state;
    state_t                 state_nxt;
    logic [4:0]             base_q;
    logic [MAX_COUNT_W-1:0] cnt_q;
    logic [MAX_COUNT_W-1:0] k_q;
    logic [31:0]            sp_q;
    logic                   err_q;

    logic [31:0]            sp_eff;
    logic                   misal;
    logic [MAX_COUNT_W-1:0] word_idx;
    logic [4:0]             dest;
    logic [31:0]            rd_addr;
    logic [31:0]            sp_final;
    logic                   last_read;
    logic                   wb_active;
`ifdef STACK_POP_ALIGN_CHECK_EN
    logic                   err_pulse;
`endif

`ifdef STACK_POP_ALIGN_CHECK_EN
    assign sp_eff = sp_in;
    assign misal  = |sp_in[1:0];
`else
    // Without the alignment check the stack pointer is treated as word-aligned.
    assign sp_eff = sp_in & 32'hFFFF_FFFC;
    assign misal  = 1'b0;
`endif

    // Data returned this cycle belongs to the read issued one cycle earlier,
    // i.e. word k-1. In DRAIN k has already reached count, so the same
    // expression yields the final word.
    assign word_idx  = k_q - ONE;
    assign dest      = base_q + 5'(word_idx);
    assign rd_addr   = sp_q + (32'(k_q) << 2);
    assign sp_final  = sp_q + (32'(cnt_q) << 2);
    assign last_read = (k_q == (cnt_q - ONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            base_q <= '0;
            cnt_q  <= '0;
            k_q    <= '0;
            sp_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q <= first_reg;
                        cnt_q  <= count;
                        sp_q   <= sp_eff;
                        k_q    <= '0;
                        err_q  <= misal;
                    end
                end
                S_READ:  k_q <= k_q + ONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        done       = 1'b0;
        wb_active  = 1'b0;
`ifdef STACK_POP_ALIGN_CHECK_EN
        err_pulse  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (misal || (count == '0)) ? S_FINISH : S_READ;
                end
            end
            S_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = rd_addr;
                wb_active = (k_q != '0);
                if (last_read) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                wb_active = 1'b1;
                state_nxt = S_FINISH;
            end
            S_FINISH: begin
                done = 1'b1;
`ifdef STACK_POP_ALIGN_CHECK_EN
                err_pulse = err_q;
`endif
                if ((cnt_q != '0) && !err_q) begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = 5'(SP_REG);
                    rf_wr_data = sp_final;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // r0 is hardwired zero: the word is still read, just not written.
        if (wb_active) begin
            rf_wr_en   = (dest != 5'd0);
            rf_wr_addr = dest;
            rf_wr_data = mem_rdata;
        end
    end

    assign busy = (state != S_IDLE);

`ifdef STACK_POP_ALIGN_CHECK_EN
    assign err = err_pulse;
`endif

endmodule

// File: tb/tb_stack_pop_sequencer.sv
// tb/tb_stack_pop_sequencer.sv - self-checking bench for stack_pop_sequencer
module tb_stack_pop_sequencer;

`ifdef STACK_POP_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_reg;
    logic [3:0]  count;
    logic [31:0] sp_in;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        busy;
    logic        done;
    logic        err_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stack_pop_sequencer #(.MAX_COUNT_W(4), .SP_REG(29)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_reg  (first_reg),
        .count      (count),
        .sp_in      (sp_in),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .busy       (busy),
        .done       (done)
`ifdef STACK_POP_ALIGN_CHECK_EN
        ,
        .err        (err_w)
`endif
    );

`ifndef STACK_POP_ALIGN_CHECK_EN
    assign err_w = 1'b0;
`endif

    // Data memory: preloaded words, otherwise a fixed hash of the address.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_1E0F;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= word_at(mem_addr);
    end

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic        wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        busy;
        logic        done;
        logic        err;
    } cyc_t;

    cyc_t obs   [0:19];
    cyc_t exp_c [0:19];
    int   exp_n;
    int   obs_n;

    // Reference schedule: cycle c after start (start sampled at end of cycle 0).
    function automatic void build_expect(input logic [4:0] first, input logic [3:0] cnt,
                                         input logic [31:0] sp_raw);
        logic [31:0] sp;
        logic [4:0]  dst;
        bit          bad;
        int          n;
        n   = int'(cnt);
        bad = ALIGN_EN && (sp_raw[1:0] != 2'b00);
        sp  = ALIGN_EN ? sp_raw : (sp_raw & ~32'h3);
        for (int i = 0; i < 20; i++) exp_c[i] = '0;
        if (bad || n == 0) begin
            exp_n         = 2;
            exp_c[1].busy = 1'b1;
            exp_c[1].done = 1'b1;
            exp_c[1].err  = bad;
            return;
        end
        exp_n = n + 3;
        for (int w = 0; w < n; w++) begin
            exp_c[w + 1].rd   = 1'b1;
            exp_c[w + 1].addr = sp + 32'(4 * w);
            dst = 5'((int'(first) + w) % 32);
            if (dst != 5'd0) begin
                exp_c[w + 2].wr    = 1'b1;
                exp_c[w + 2].waddr = dst;
                exp_c[w + 2].wdata = word_at(sp + 32'(4 * w));
            end
        end
        for (int c = 1; c <= n + 2; c++) exp_c[c].busy = 1'b1;
        exp_c[n + 2].done  = 1'b1;
        exp_c[n + 2].wr    = 1'b1;
        exp_c[n + 2].waddr = 5'd29;
        exp_c[n + 2].wdata = sp + 32'(4 * n);
    endfunction

    // Called at a negedge of an idle cycle; returns at the negedge of the
    // first idle cycle after the pop, so consecutive calls are back-to-back.
    task automatic do_pop(input logic [4:0] first, input logic [3:0] cnt,
                          input logic [31:0] sp, input bit noise);
        bit bad;
        bad       = ALIGN_EN && (sp[1:0] != 2'b00);
        obs_n     = (bad || cnt == 4'd0) ? 2 : int'(cnt) + 3;
        first_reg = first;
        count     = cnt;
        sp_in     = sp;
        start     = 1'b1;
        for (int c = 1; c <= obs_n; c++) begin
            @(negedge clk);
            obs[c] = '{mem_rd_en, mem_addr, rf_wr_en, rf_wr_addr, rf_wr_data, busy, done, err_w};
            if (noise && c < obs_n) begin
                start     = 1'b1;
                first_reg = 5'($urandom);
                count     = 4'($urandom);
                sp_in     = $urandom;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; first_reg = '0; count = '0; sp_in = '0;
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({mem_rd_en, mem_addr, rf_wr_en, rf_wr_addr, rf_wr_data, busy, done, err_w} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rd=%b addr=%h wr=%b waddr=%0d wdata=%h busy=%b done=%b err=%b, want all 0",
                     mem_rd_en, mem_addr, rf_wr_en, rf_wr_addr, rf_wr_data, busy, done, err_w);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_single_pop();
        mem[32'h1001_0004] = 32'h0000_0100;
        do_pop(5'd16, 4'd1, 32'h1001_0004, 1'b0);
        checks++;
        if (obs[1].rd !== 1'b1 || obs[1].addr !== 32'h1001_0004) begin
            failures++;
            $display("FAIL single_read: got rd=%b addr=%h want 1 10010004", obs[1].rd, obs[1].addr);
        end
        checks++;
        if (obs[2].wr !== 1'b1 || obs[2].waddr !== 5'd16 || obs[2].wdata !== 32'h0000_0100) begin
            failures++;
            $display("FAIL single_write: got wr=%b r%0d=%h want 1 r16=00000100", obs[2].wr, obs[2].waddr, obs[2].wdata);
        end
        checks++;
        if (obs[3].wr !== 1'b1 || obs[3].waddr !== 5'd29 || obs[3].wdata !== 32'h1001_0008 || obs[3].done !== 1'b1) begin
            failures++;
            $display("FAIL single_sp: got wr=%b r%0d=%h done=%b want 1 r29=10010008 1",
                     obs[3].wr, obs[3].waddr, obs[3].wdata, obs[3].done);
        end
        checks++;
        if (obs[4].busy !== 1'b0 || obs[4].wr !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got busy=%b wr=%b want 0 0", obs[4].busy, obs[4].wr);
        end
    endtask

    task automatic test_block_pop();
        for (int w = 0; w < 4; w++) mem[32'h7FFF_EFF0 + 32'(4 * w)] = 32'hA + 32'(w);
        do_pop(5'd8, 4'd4, 32'h7FFF_EFF0, 1'b0);
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (obs[w + 2].wr !== 1'b1 || obs[w + 2].waddr !== 5'(8 + w) || obs[w + 2].wdata !== 32'hA + 32'(w)
                || obs[w + 2].rd !== (w < 3)) begin
                failures++;
                $display("FAIL block_write%0d: got rd=%b wr=%b r%0d=%h want rd=%b wr=1 r%0d=%h",
                         w, obs[w + 2].rd, obs[w + 2].wr, obs[w + 2].waddr, obs[w + 2].wdata, w < 3, 8 + w, 32'hA + 32'(w));
            end
        end
        checks++;
        if (obs[6].wr !== 1'b1 || obs[6].waddr !== 5'd29 || obs[6].wdata !== 32'h7FFF_F000 || obs[6].done !== 1'b1) begin
            failures++;
            $display("FAIL block_sp: got wr=%b r%0d=%h done=%b want 1 r29=7ffff000 1",
                     obs[6].wr, obs[6].waddr, obs[6].wdata, obs[6].done);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want_addr [3];
        want_addr[0] = 32'hFFFF_FFFC; want_addr[1] = 32'h0000_0000; want_addr[2] = 32'h0000_0004;
        do_pop(5'd30, 4'd3, 32'hFFFF_FFFC, 1'b0);
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (obs[w + 1].rd !== 1'b1 || obs[w + 1].addr !== want_addr[w]) begin
                failures++;
                $display("FAIL wrap_read%0d: got rd=%b addr=%h want 1 %h", w, obs[w + 1].rd, obs[w + 1].addr, want_addr[w]);
            end
        end
        checks++;
        if (obs[2].wr !== 1'b1 || obs[2].waddr !== 5'd30 || obs[3].wr !== 1'b1 || obs[3].waddr !== 5'd31) begin
            failures++;
            $display("FAIL wrap_dest: got %b/r%0d %b/r%0d want 1/r30 1/r31", obs[2].wr, obs[2].waddr, obs[3].wr, obs[3].waddr);
        end
        checks++;
        if (obs[4].wr !== 1'b0) begin
            failures++;
            $display("FAIL wrap_r0: got wr=%b waddr=%0d want wr=0", obs[4].wr, obs[4].waddr);
        end
        checks++;
        if (obs[5].wr !== 1'b1 || obs[5].waddr !== 5'd29 || obs[5].wdata !== 32'h0000_0008) begin
            failures++;
            $display("FAIL wrap_sp: got wr=%b r%0d=%h want 1 r29=00000008", obs[5].wr, obs[5].waddr, obs[5].wdata);
        end
    endtask

    task automatic test_zero_count();
        do_pop(5'd7, 4'd0, 32'h0000_1000, 1'b1);
        checks++;
        if (obs[1].busy !== 1'b1 || obs[1].done !== 1'b1 || obs[1].rd !== 1'b0 || obs[1].wr !== 1'b0) begin
            failures++;
            $display("FAIL zero_cycle1: got busy=%b done=%b rd=%b wr=%b want 1 1 0 0",
                     obs[1].busy, obs[1].done, obs[1].rd, obs[1].wr);
        end
        checks++;
        if (obs[2].busy !== 1'b0 || obs[2].done !== 1'b0 || obs[2].rd !== 1'b0 || obs[2].wr !== 1'b0) begin
            failures++;
            $display("FAIL zero_ignore_start: got busy=%b done=%b rd=%b wr=%b want 0 0 0 0",
                     obs[2].busy, obs[2].done, obs[2].rd, obs[2].wr);
        end
    endtask

    task automatic test_reset_mid_pop();
        first_reg = 5'd1; count = 4'd8; sp_in = 32'h0000_2000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({mem_rd_en, mem_addr, rf_wr_en, rf_wr_addr, rf_wr_data, busy, done, err_w} !== '0) begin
            failures++;
            $display("FAIL midpop_reset_outputs: got rd=%b wr=%b busy=%b done=%b want all 0",
                     mem_rd_en, rf_wr_en, busy, done);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rf_wr_en !== 1'b0 || mem_rd_en !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midpop_quiet%0d: got wr=%b r%0d rd=%b busy=%b want 0 0 0", i, rf_wr_en, rf_wr_addr, mem_rd_en, busy);
            end
            if (i == 2) reset = 1'b1;
        end
        do_pop(5'd4, 4'd2, 32'h0000_0400, 1'b0);
        checks++;
        if (obs[2].wr !== 1'b1 || obs[2].waddr !== 5'd4 || obs[2].wdata !== word_at(32'h400)
            || obs[4].waddr !== 5'd29 || obs[4].wdata !== 32'h0000_0408 || obs[4].done !== 1'b1) begin
            failures++;
            $display("FAIL midpop_restart: got r%0d=%h r%0d=%h done=%b want r4=%h r29=00000408 1",
                     obs[2].waddr, obs[2].wdata, obs[4].waddr, obs[4].wdata, obs[4].done, word_at(32'h400));
        end
    endtask

    task automatic test_misaligned();
        do_pop(5'd5, 4'd2, 32'h1001_0006, 1'b0);
`ifdef STACK_POP_ALIGN_CHECK_EN
        checks++;
        if (obs[1].err !== 1'b1 || obs[1].done !== 1'b1 || obs[1].rd !== 1'b0 || obs[1].wr !== 1'b0
            || obs[2].err !== 1'b0 || obs[2].busy !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_err: got err=%b done=%b rd=%b wr=%b next err=%b busy=%b want 1 1 0 0 0 0",
                     obs[1].err, obs[1].done, obs[1].rd, obs[1].wr, obs[2].err, obs[2].busy);
        end
`else
        checks++;
        if (obs[1].rd !== 1'b1 || obs[1].addr !== 32'h1001_0004 || obs[2].addr !== 32'h1001_0008
            || obs[4].wdata !== 32'h1001_000C || obs[4].waddr !== 5'd29) begin
            failures++;
            $display("FAIL misaligned_forced: got addr=%h,%h r%0d=%h want 10010004,10010008 r29=1001000c",
                     obs[1].addr, obs[2].addr, obs[4].waddr, obs[4].wdata);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [4:0]  f;
        logic [3:0]  n;
        logic [31:0] s;
        for (int p = 0; p < 2; p++) begin
            f = 5'($urandom); n = 4'($urandom_range(1, 15)); s = $urandom;
            build_expect(f, n, s);
            do_pop(f, n, s, 1'b1);
            for (int c = 1; c <= exp_n; c++) begin
                checks++;
                if (obs[c].rd !== exp_c[c].rd || (exp_c[c].rd && obs[c].addr !== exp_c[c].addr)) begin
                    failures++;
                    $display("FAIL b2b%0d_read c%0d: got rd=%b addr=%h want rd=%b addr=%h",
                             p, c, obs[c].rd, obs[c].addr, exp_c[c].rd, exp_c[c].addr);
                end
                checks++;
                if (obs[c].wr !== exp_c[c].wr || (exp_c[c].wr && (obs[c].waddr !== exp_c[c].waddr || obs[c].wdata !== exp_c[c].wdata))) begin
                    failures++;
                    $display("FAIL b2b%0d_write c%0d: got wr=%b r%0d=%h want wr=%b r%0d=%h",
                             p, c, obs[c].wr, obs[c].waddr, obs[c].wdata, exp_c[c].wr, exp_c[c].waddr, exp_c[c].wdata);
                end
                checks++;
                if ({obs[c].busy, obs[c].done, obs[c].err} !== {exp_c[c].busy, exp_c[c].done, exp_c[c].err}) begin
                    failures++;
                    $display("FAIL b2b%0d_ctl c%0d: got busy/done/err=%b%b%b want %b%b%b", p, c,
                             obs[c].busy, obs[c].done, obs[c].err, exp_c[c].busy, exp_c[c].done, exp_c[c].err);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]  f;
        logic [3:0]  n;
        logic [31:0] s;
        for (int it = 0; it < 40; it++) begin
            f = 5'($urandom);
            n = 4'($urandom);
            s = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31))) : $urandom;
            if (it == 0) n = 4'd15;
            build_expect(f, n, s);
            do_pop(f, n, s, 1'b1);
            for (int c = 1; c <= exp_n; c++) begin
                checks++;
                if (obs[c].rd !== exp_c[c].rd || (exp_c[c].rd && obs[c].addr !== exp_c[c].addr)) begin
                    failures++;
                    $display("FAIL rand%0d_read c%0d: got rd=%b addr=%h want rd=%b addr=%h",
                             it, c, obs[c].rd, obs[c].addr, exp_c[c].rd, exp_c[c].addr);
                end
                checks++;
                if (obs[c].wr !== exp_c[c].wr || (exp_c[c].wr && (obs[c].waddr !== exp_c[c].waddr || obs[c].wdata !== exp_c[c].wdata))) begin
                    failures++;
                    $display("FAIL rand%0d_write c%0d: got wr=%b r%0d=%h want wr=%b r%0d=%h",
                             it, c, obs[c].wr, obs[c].waddr, obs[c].wdata, exp_c[c].wr, exp_c[c].waddr, exp_c[c].wdata);
                end
                checks++;
                if ({obs[c].busy, obs[c].done, obs[c].err} !== {exp_c[c].busy, exp_c[c].done, exp_c[c].err}) begin
                    failures++;
                    $display("FAIL rand%0d_ctl c%0d: got busy/done/err=%b%b%b want %b%b%b", it, c,
                             obs[c].busy, obs[c].done, obs[c].err, exp_c[c].busy, exp_c[c].done, exp_c[c].err);
                end
            end
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_pop();
        test_block_pop();
        test_wrap();
        test_zero_count();
        test_reset_mid_pop();
        test_misaligned();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
